// File: rtl/waveform_generator_if.sv
// Configuration and sample bus for waveform_generator.
// The master drives configuration/control; the slave (generator) drives the sample outputs.
interface waveform_generator_if #(
  parameter int unsigned DATA_WIDTH = 12
) ();

  logic                  enable;
  logic                  sync;
  logic [1:0]            mode;
  logic [DATA_WIDTH-1:0] step;
  logic [DATA_WIDTH-1:0] min_val;
  logic [DATA_WIDTH-1:0] max_val;
  logic [DATA_WIDTH-1:0] wave_out;
  logic                  period_pulse;

  modport master (
    output enable,
    output sync,
    output mode,
    output step,
    output min_val,
    output max_val,
    input  wave_out,
    input  period_pulse
  );

  modport slave (
    input  enable,
    input  sync,
    input  mode,
    input  step,
    input  min_val,
    input  max_val,
    output wave_out,
    output period_pulse
  );

endinterface

// File: rtl/waveform_generator.sv
// Multi-mode waveform source (triangle, saw up/down, square) between shadowed min/max limits.
// Configuration is only taken on sync or at a period boundary, so a period never glitches.
module waveform_generator #(
  parameter int unsigned DATA_WIDTH = 12
) (
  input  logic                 ref_clk,
  input  logic                 rstn,
  waveform_generator_if.slave  wg_io
);

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [DATA_WIDTH:0]   ext_t;

  typedef enum logic [1:0] {
    ModeTri    = 2'd0,
    ModeSawUp  = 2'd1,
    ModeSawDn  = 2'd2,
    ModeSquare = 2'd3
  } mode_e;

  data_t wave_q, wave_d;
  logic  pulse_q, pulse_d;
  logic  down_q, down_d;
  data_t cnt_q, cnt_d;
  logic  level_q, level_d;
  mode_e mode_s_q, mode_s_d;
  data_t step_s_q, step_s_d;
  data_t min_s_q, min_s_d;
  data_t max_s_q, max_s_d;

  data_t              step_eff;
  ext_t               sum;
  logic signed [DATA_WIDTH:0] diff;
  logic               cfg_bad;
  logic               in_bad;
  logic               load;
  mode_e              mode_in;

  assign mode_in  = mode_e'(wg_io.mode);
  assign step_eff = (step_s_q == '0) ? data_t'(1) : step_s_q;
  // One extra bit keeps overflow/underflow visible to the limit compares.
  assign sum      = {1'b0, wave_q} + {1'b0, step_eff};
  assign diff     = $signed({1'b0, wave_q}) - $signed({1'b0, step_eff});
  assign cfg_bad  = (min_s_q >= max_s_q);
  assign in_bad   = (wg_io.min_val >= wg_io.max_val);

  always_comb begin
    wave_d   = wave_q;
    pulse_d  = 1'b0;
    down_d   = down_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    load     = 1'b0;

    if (wg_io.sync) begin
      load    = 1'b1;
      down_d  = 1'b0;
      cnt_d   = '0;
      level_d = (mode_in == ModeSquare);
      if (in_bad) begin
        wave_d = wg_io.min_val;
      end else begin
        wave_d  = (mode_in == ModeTri || mode_in == ModeSawUp) ? wg_io.min_val : wg_io.max_val;
        pulse_d = 1'b1;
      end
    end else if (wg_io.enable) begin
      if (cfg_bad) begin
        wave_d = min_s_q;
      end else begin
        unique case (mode_s_q)
          ModeTri: begin
            if (!down_q) begin
              if (sum >= {1'b0, max_s_q}) begin
                wave_d = max_s_q;
                down_d = 1'b1;
              end else begin
                wave_d = sum[DATA_WIDTH-1:0];
              end
            end else if (diff <= $signed({1'b0, min_s_q})) begin
              load    = 1'b1;
              wave_d  = wg_io.min_val;
              down_d  = 1'b0;
              pulse_d = 1'b1;
            end else begin
              wave_d = diff[DATA_WIDTH-1:0];
            end
          end
          ModeSawUp: begin
            if (wave_q == max_s_q) begin
              load    = 1'b1;
              wave_d  = wg_io.min_val;
              pulse_d = 1'b1;
            end else if (sum >= {1'b0, max_s_q}) begin
              wave_d = max_s_q;
            end else begin
              wave_d = sum[DATA_WIDTH-1:0];
            end
          end
          ModeSawDn: begin
            if (wave_q == min_s_q) begin
              load    = 1'b1;
              wave_d  = wg_io.max_val;
              pulse_d = 1'b1;
            end else if (diff <= $signed({1'b0, min_s_q})) begin
              wave_d = min_s_q;
            end else begin
              wave_d = diff[DATA_WIDTH-1:0];
            end
          end
          ModeSquare: begin
            if (cnt_q == step_eff - data_t'(1)) begin
              cnt_d   = '0;
              level_d = ~level_q;
              if (!level_q) begin
                load    = 1'b1;
                wave_d  = wg_io.max_val;
                pulse_d = 1'b1;
              end else begin
                wave_d = min_s_q;
              end
            end else begin
              cnt_d = cnt_q + data_t'(1);
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    mode_s_d = mode_s_q;
    step_s_d = step_s_q;
    min_s_d  = min_s_q;
    max_s_d  = max_s_q;
    if (load) begin
      mode_s_d = mode_in;
      step_s_d = wg_io.step;
      min_s_d  = wg_io.min_val;
      max_s_d  = wg_io.max_val;
    end
  end

  always_ff @(posedge ref_clk or negedge rstn) begin
    if (!rstn) begin
      wave_q   <= '0;
      pulse_q  <= 1'b0;
      down_q   <= 1'b0;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      mode_s_q <= ModeTri;
      step_s_q <= data_t'(1);
      min_s_q  <= '0;
      max_s_q  <= '1;
    end else begin
      wave_q   <= wave_d;
      pulse_q  <= pulse_d;
      down_q   <= down_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      mode_s_q <= mode_s_d;
      step_s_q <= step_s_d;
      min_s_q  <= min_s_d;
      max_s_q  <= max_s_d;
    end
  end

  assign wg_io.wave_out     = wave_q;
  assign wg_io.period_pulse = pulse_q;

endmodule

// File: tb/tb_waveform_generator.sv
// Bench for waveform_generator: directed waveform sequences, then randomized traffic
// compared cycle by cycle against an integer reference model.
module tb_waveform_generator;

  localparam int unsigned DW   = 4;
  localparam int          MAXV = 15;

  logic ref_clk = 1'b0;
  logic rstn    = 1'b0;

  waveform_generator_if #(.DATA_WIDTH(DW)) wif ();

  waveform_generator #(.DATA_WIDTH(DW)) dut (
    .ref_clk (ref_clk),
    .rstn    (rstn),
    .wg_io   (wif.slave)
  );

  always #5 ref_clk = ~ref_clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state: sample, pulse, direction, square count/level, shadow config.
  int m_wave, m_pulse, m_cnt;
  bit m_up, m_lvl;
  int s_mode, s_step, s_min, s_max;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic void model_reset();
    m_wave = 0; m_pulse = 0; m_cnt = 0; m_up = 1'b1; m_lvl = 1'b0;
    s_mode = 0; s_step = 1; s_min = 0; s_max = MAXV;
  endfunction

  function automatic void model_load();
    s_mode = int'(wif.mode);
    s_step = int'(wif.step);
    s_min  = int'(wif.min_val);
    s_max  = int'(wif.max_val);
  endfunction

  function automatic void model_edge();
    int se;
    if (wif.sync) begin
      model_load();
      m_up = 1'b1; m_cnt = 0; m_lvl = (s_mode == 3);
      if (s_min >= s_max) begin
        m_wave = s_min; m_pulse = 0;
      end else begin
        m_wave = (s_mode < 2) ? s_min : s_max; m_pulse = 1;
      end
      return;
    end
    m_pulse = 0;
    if (!wif.enable) return;
    if (s_min >= s_max) begin
      m_wave = s_min;
      return;
    end
    se = (s_step == 0) ? 1 : s_step;
    case (s_mode)
      0: begin
        if (m_up) begin
          if (m_wave + se >= s_max) begin m_wave = s_max; m_up = 1'b0; end
          else m_wave = m_wave + se;
        end else if (m_wave - se <= s_min) begin
          model_load(); m_wave = s_min; m_up = 1'b1; m_pulse = 1;
        end else m_wave = m_wave - se;
      end
      1: begin
        if (m_wave == s_max) begin model_load(); m_wave = s_min; m_pulse = 1; end
        else m_wave = (m_wave + se >= s_max) ? s_max : m_wave + se;
      end
      2: begin
        if (m_wave == s_min) begin model_load(); m_wave = s_max; m_pulse = 1; end
        else m_wave = (m_wave - se <= s_min) ? s_min : m_wave - se;
      end
      default: begin
        if (m_cnt == se - 1) begin
          m_cnt = 0; m_lvl = !m_lvl;
          if (m_lvl) begin model_load(); m_wave = s_max; m_pulse = 1; end
          else m_wave = s_min;
        end else m_cnt = m_cnt + 1;
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge ref_clk);
    model_edge();
    #1;
    chk("mdl_wave", 32'(wif.wave_out), m_wave);
    chk("mdl_pulse", 32'(wif.period_pulse), m_pulse);
  endtask

  task automatic exp1(input string tag, input int w, input int p);
    tick();
    chk({tag, "_wave"}, 32'(wif.wave_out), w);
    chk({tag, "_pulse"}, 32'(wif.period_pulse), p);
  endtask

  task automatic set_cfg(input int md, input int st, input int mn, input int mx);
    wif.mode    = 2'(md);
    wif.step    = DW'(st);
    wif.min_val = DW'(mn);
    wif.max_val = DW'(mx);
  endtask

  task automatic sync_to(input int md, input int st, input int mn, input int mx, input bit en,
                         input int w, input int p);
    set_cfg(md, st, mn, mx);
    wif.enable = en;
    wif.sync   = 1'b1;
    exp1("sync", w, p);
    wif.sync   = 1'b0;
  endtask

  initial begin
    int mn;
    wif.enable = 1'b0;
    wif.sync   = 1'b0;
    set_cfg(0, 1, 0, MAXV);
    model_reset();
    #2;
    chk("rst_wave", 32'(wif.wave_out), 0);
    chk("rst_pulse", 32'(wif.period_pulse), 0);
    #10;
    rstn       = 1'b1;
    wif.enable = 1'b1;

    // Default triangle 0..15 with step 1: pulse only on the second 0.
    for (int k = 1; k <= 32; k++) begin
      exp1("tri_def", (k <= 15) ? k : ((k <= 30) ? 30 - k : k - 30), (k == 30) ? 1 : 0);
    end

    sync_to(0, 4, 3, 12, 1'b1, 3, 1);
    exp1("tri", 7, 0);  exp1("tri", 11, 0); exp1("tri", 12, 0); exp1("tri", 8, 0);
    exp1("tri", 4, 0);  exp1("tri", 3, 1);  exp1("tri", 7, 0);
    wif.step = DW'(1);  // takes effect only at the next period start
    exp1("tri_st", 11, 0); exp1("tri_st", 12, 0); exp1("tri_st", 8, 0); exp1("tri_st", 4, 0);
    exp1("tri_st", 3, 1);  exp1("tri_st", 4, 0);  exp1("tri_st", 5, 0);

    sync_to(1, 3, 2, 9, 1'b1, 2, 1);
    exp1("sawup", 5, 0); exp1("sawup", 8, 0); exp1("sawup", 9, 0);
    exp1("sawup", 2, 1); exp1("sawup", 5, 0);

    sync_to(2, 3, 2, 9, 1'b1, 9, 1);
    exp1("sawdn", 6, 0); exp1("sawdn", 3, 0); exp1("sawdn", 2, 0);
    exp1("sawdn", 9, 1); exp1("sawdn", 6, 0);

    sync_to(3, 3, 1, 14, 1'b1, 14, 1);
    exp1("sq", 14, 0); exp1("sq", 14, 0); exp1("sq", 1, 0); exp1("sq", 1, 0);
    exp1("sq", 1, 0);  exp1("sq", 14, 1); exp1("sq", 14, 0);

    sync_to(3, 0, 1, 14, 1'b1, 14, 1);
    exp1("sq0", 1, 0); exp1("sq0", 14, 1); exp1("sq0", 1, 0); exp1("sq0", 14, 1);

    sync_to(0, 1, 0, MAXV, 1'b1, 0, 1);
    exp1("hold", 1, 0); exp1("hold", 2, 0); exp1("hold", 3, 0);
    wif.enable = 1'b0;
    for (int i = 0; i < 5; i++) exp1("hold_off", 3, 0);
    wif.enable = 1'b1;
    exp1("hold_on", 4, 0);
    sync_to(2, 1, 2, 9, 1'b0, 9, 1);
    exp1("sync_noen", 9, 0);
    wif.enable = 1'b1;
    exp1("sync_noen", 8, 0);

    sync_to(0, 1, 10, 10, 1'b1, 10, 0);
    for (int i = 0; i < 5; i++) exp1("invalid", 10, 0);
    sync_to(1, 1, 0, MAXV, 1'b1, 0, 1);
    exp1("recover", 1, 0);

    // Asynchronous reset while a pulse is showing.
    sync_to(1, 1, 5, MAXV, 1'b1, 5, 1);
    rstn = 1'b0;
    #2;
    chk("arst_wave", 32'(wif.wave_out), 0);
    chk("arst_pulse", 32'(wif.period_pulse), 0);
    model_reset();
    @(negedge ref_clk);
    @(negedge ref_clk);
    rstn = 1'b1;
    exp1("post_rst", 1, 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      wif.sync   = ($urandom_range(0, 15) == 0);
      wif.enable = ($urandom_range(0, 7) != 0);
      mn         = int'($urandom_range(0, 8));
      set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), mn,
              int'($urandom_range(mn, MAXV)));
      tick();
    end
    wif.sync = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
